// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: bundle of the producer handshake and FIFO write-port signals
// seen by fifo_wr_arbiter.
//
// Parameters
//   NUM_REQ     number of producers (2..16)
//   FIFO_WIDTH  data width of each producer and of the FIFO write port
//
// Signals
//   req_valid     producer -> arbiter  per-producer data valid
//   req_data      producer -> arbiter  packed data, producer i at [i*FIFO_WIDTH +: FIFO_WIDTH]
//   req_ready     arbiter -> producer  per-producer accept (at most one bit high)
//   fifoFull      FIFO -> arbiter      FIFO full flag
//   fifoWrEn      arbiter -> FIFO      write enable
//   fifoWrData    arbiter -> FIFO      write data
//   grant_id      arbiter -> observer  current eligible/owning producer
//   burst_active  arbiter -> observer  high while a burst grant is held
//
// Modports
//   master  arbiter side
//   slave   environment side (producers, FIFO, observers)

interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_WIDTH = 8
);
  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifoFull;
  logic                          fifoWrEn;
  logic [FIFO_WIDTH-1:0]         fifoWrData;
  logic [IdW-1:0]                grant_id;
  logic                          burst_active;

  modport master (
    input  req_valid,
    input  req_data,
    input  fifoFull,
    output req_ready,
    output fifoWrEn,
    output fifoWrData,
    output grant_id,
    output burst_active
  );

  modport slave (
    output req_valid,
    output req_data,
    output fifoFull,
    input  req_ready,
    input  fifoWrEn,
    input  fifoWrData,
    input  grant_id,
    input  burst_active
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ
// valid/ready producers. A grant may be held for up to MAX_BURST consecutive beats so
// that a producer's back-to-back words land contiguously in the FIFO. No write is
// issued while fifoFull is high. The accept decision and the FIFO write are purely
// combinational (zero-cycle latency).
//
// Parameters
//   NUM_REQ     number of producers (2..16)
//   FIFO_WIDTH  data width per producer and of the FIFO write data
//   MAX_BURST   maximum consecutive beats per grant (1 disables bursting)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset; also forces req_ready/fifoWrEn low
//   bus        fifo_wr_arbiter_if.master (handshake, FIFO write port, grant status)
//   cnt_clr    (FIFOARB_GRANT_CNT_EN only) synchronous clear of the beat counters
//   grant_cnt  (FIFOARB_GRANT_CNT_EN only) NUM_REQ x 16-bit saturating accepted-beat
//              counters, producer i at [i*16 +: 16]
//
// Build option
//   FIFOARB_GRANT_CNT_EN  when defined, adds the per-producer beat counters.

module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef FIFOARB_GRANT_CNT_EN
  input  logic                  cnt_clr,
  output logic [NUM_REQ*16-1:0] grant_cnt,
`endif
  fifo_wr_arbiter_if.master     bus
);

  localparam int unsigned    IdW      = $clog2(NUM_REQ);
  localparam int unsigned    CntW     = $clog2(MAX_BURST + 1);
  localparam logic [IdW-1:0] LastId   = IdW'(NUM_REQ - 1);
  localparam logic [CntW-1:0] BurstLen = CntW'(MAX_BURST);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]  cur_q, cur_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;

  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] accept;
  logic [IdW-1:0]     gid;
  logic               burst;

  function automatic logic [IdW-1:0] wrap_inc(input logic [IdW-1:0] x);
    return (x == LastId) ? '0 : x + 1'b1;
  endfunction

  // Round-robin search: first valid producer at or after rr_ptr, wrapping.
  logic [IdW-1:0] winner;
  logic [IdW-1:0] idx;
  logic           found;

  always_comb begin
    winner = rr_ptr_q;
    idx    = rr_ptr_q;
    found  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IdW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cur_d      = cur_q;
    beat_cnt_d = beat_cnt_q;
    ready      = '0;
    gid        = rr_ptr_q;
    burst      = 1'b0;

    case (state_q)
      StIdle: begin
        if (found) begin
          gid = winner;
        end
        if (found && !bus.fifoFull) begin
          ready[winner] = 1'b1;
          if (MAX_BURST == 1) begin
            rr_ptr_d = wrap_inc(winner);
          end else begin
            state_d    = StBurst;
            cur_d      = winner;
            beat_cnt_d = CntW'(1);
          end
        end
      end

      StBurst: begin
        gid   = cur_q;
        burst = 1'b1;
        if (!bus.req_valid[cur_q]) begin
          // Owner ran dry: release the grant, costing this cycle as a bubble.
          state_d  = StIdle;
          rr_ptr_d = wrap_inc(cur_q);
        end else if (!bus.fifoFull) begin
          ready[cur_q] = 1'b1;
          beat_cnt_d   = beat_cnt_q + 1'b1;
          if (beat_cnt_d == BurstLen) begin
            state_d  = StIdle;
            rr_ptr_d = wrap_inc(cur_q);
          end
        end
        // fifoFull with owner valid: hold everything.
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Nothing is accepted while reset is asserted.
    if (reset) begin
      ready = '0;
      gid   = '0;
      burst = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      cur_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_q      <= cur_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign accept           = bus.req_valid & ready;
  assign bus.req_ready    = ready;
  assign bus.fifoWrEn     = |accept;
  assign bus.fifoWrData   = bus.req_data[gid*FIFO_WIDTH +: FIFO_WIDTH];
  assign bus.grant_id     = gid;
  assign bus.burst_active = burst;

`ifdef FIFOARB_GRANT_CNT_EN
  logic [15:0] cnt_q [NUM_REQ];

  // Clear has priority over a same-cycle accept.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (reset || cnt_clr) begin
        cnt_q[i] <= '0;
      end else if (accept[i] && (cnt_q[i] != 16'hFFFF)) begin
        cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*16 +: 16] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter. Two instances share one set of inputs:
// dut_a with MAX_BURST=1 and dut_b with MAX_BURST=4; `phase` selects which one is
// observed. A behavioural model (grant holder / beats taken / next pointer) predicts
// every cycle's accepted producer, grant and burst flag.

module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] valid_v;
  logic [N*W-1:0] data_v;
  logic         full_v;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .FIFO_WIDTH(W)) ifa ();
  fifo_wr_arbiter_if #(.NUM_REQ(N), .FIFO_WIDTH(W)) ifb ();

  assign ifa.req_valid = valid_v;
  assign ifa.req_data  = data_v;
  assign ifa.fifoFull  = full_v;
  assign ifb.req_valid = valid_v;
  assign ifb.req_data  = data_v;
  assign ifb.fifoFull  = full_v;

`ifdef FIFOARB_GRANT_CNT_EN
  logic           cnt_clr;
  logic [N*16-1:0] gcnt_a, gcnt_b;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(1)) dut_a (
    .clk      (clk),
    .reset    (rst),
`ifdef FIFOARB_GRANT_CNT_EN
    .cnt_clr  (cnt_clr),
    .grant_cnt(gcnt_a),
`endif
    .bus      (ifa.master)
  );

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(4)) dut_b (
    .clk      (clk),
    .reset    (rst),
`ifdef FIFOARB_GRANT_CNT_EN
    .cnt_clr  (cnt_clr),
    .grant_cnt(gcnt_b),
`endif
    .bus      (ifb.master)
  );

  int phase;
  int mb;

  logic [N-1:0] o_ready;
  logic         o_wren;
  logic [W-1:0] o_data;
  logic [1:0]   o_gid;
  logic         o_burst;

  always_comb begin
    if (phase == 0) begin
      o_ready = ifa.req_ready;
      o_wren  = ifa.fifoWrEn;
      o_data  = ifa.fifoWrData;
      o_gid   = ifa.grant_id;
      o_burst = ifa.burst_active;
    end else begin
      o_ready = ifb.req_ready;
      o_wren  = ifb.fifoWrEn;
      o_data  = ifb.fifoWrData;
      o_gid   = ifb.grant_id;
      o_burst = ifb.burst_active;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: holder of the current grant (-1 = none), beats taken in it, next RR start.
  int m_owner, m_taken, m_ptr;
  int last_acc;

  // Raise valid with fresh data on producer i unless it already has a pending beat.
  task automatic want(input int i);
    if (!valid_v[i]) begin
      valid_v[i]       = 1'b1;
      data_v[i*W +: W] = W'($urandom);
    end
  endtask

  // Inputs are set at posedge+1; check at posedge+4; retire the accepted beat after
  // the next edge. Returns at posedge+1.
  task automatic step();
    int acc, gid, w, idx;
    bit bur;
    acc = -1;
    gid = 0;
    bur = 1'b0;
    #3;
    if (rst) begin
      chk_eq("rst_ready", 32'(o_ready), 0);
      chk_eq("rst_wren", 32'(o_wren), 0);
      m_owner = -1;
      m_taken = 0;
      m_ptr   = 0;
    end else begin
      if (m_owner < 0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (w < 0 && valid_v[idx]) w = idx;
        end
        gid = (w >= 0) ? w : m_ptr;
        if (w >= 0 && !full_v) begin
          acc = w;
          if (mb == 1) m_ptr = (w + 1) % N;
          else begin
            m_owner = w;
            m_taken = 1;
          end
        end
      end else begin
        gid = m_owner;
        bur = 1'b1;
        if (!valid_v[m_owner]) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end else if (!full_v) begin
          acc = m_owner;
          m_taken++;
          if (m_taken == mb) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
          end
        end
      end
      chk_eq("grant_id", 32'(o_gid), gid);
      chk_eq("burst_active", 32'(o_burst), 32'(bur));
      chk_eq("req_ready", 32'(o_ready), (acc >= 0) ? (1 << acc) : 0);
      chk_eq("fifoWrEn", 32'(o_wren), (acc >= 0) ? 1 : 0);
      if (acc >= 0) chk_eq("fifoWrData", 32'(o_data), 32'(data_v[acc*W +: W]));
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    if (acc >= 0) valid_v[acc] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic random_run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(99) < 45) want(i);
      end
      full_v = ($urandom_range(9) < 2);
      rst    = ($urandom_range(59) == 0);
      step();
    end
    rst    = 1'b0;
    full_v = 1'b0;
  endtask

  int seq_q[$];
  int n1;
  int exp_b[16] = '{2, 2, 2, 2, 0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 0, 0};
  int exp_d[4]  = '{3, 3, -1, 0};

  initial begin
    phase   = 0;
    mb      = 1;
    rst     = 1'b1;
    valid_v = '1;
    data_v  = '0;
    full_v  = 1'b0;
    m_owner = -1;
    m_taken = 0;
    m_ptr   = 0;
    last_acc = -1;
`ifdef FIFOARB_GRANT_CNT_EN
    cnt_clr = 1'b0;
`endif
    @(posedge clk);
    #1;
    // Reset cycle with every producer valid: nothing may be accepted.
    step();
    rst = 1'b0;

    // MAX_BURST=1, all producers always valid: strict 0,1,2,3 rotation.
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) want(i);
      step();
      chk_eq("rr_seq", 32'(last_acc), 32'(c % N));
    end
    random_run(400);

    // MAX_BURST=4.
    phase = 1;
    mb    = 4;
    valid_v = '0;
    do_reset();

    // Producer 2 valid for 10 beats (starting alone), producer 0 valid throughout.
    n1 = 0;
    seq_q.delete();
    want(2);
    for (int c = 0; c < 22; c++) begin
      if (c > 0) want(0);
      if (n1 < 10) want(2);
      step();
      if (last_acc == 2) n1++;
      seq_q.push_back(last_acc);
    end
    for (int k = 0; k < 16; k++) chk_eq("burst_seq", 32'(seq_q[k]), 32'(exp_b[k]));

    // Stall mid-burst: producer 1 takes 2 beats, FIFO full 5 cycles, then finishes.
    valid_v = '0;
    do_reset();
    n1 = 0;
    for (int c = 0; c < 9; c++) begin
      want(1);
      full_v = (c >= 2 && c < 7);
      step();
      if (last_acc == 1) n1++;
    end
    full_v = 1'b0;
    chk_eq("stall_beats", 32'(n1), 4);
    step();
    chk_eq("stall_done_burst", 32'(o_burst), 0);

    // Producer 3 drops after 2 beats with producer 0 waiting: one bubble, then 0.
    valid_v = '0;
    do_reset();
    seq_q.delete();
    want(3);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) want(0);
      if (c < 2) want(3);
      step();
      seq_q.push_back(last_acc);
    end
    for (int k = 0; k < 4; k++) chk_eq("drop_seq", 32'(seq_q[k]), 32'(exp_d[k]));

    // Reset in the middle of producer 2's burst.
    valid_v = '0;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      want(2);
      step();
    end
    want(2);
    want(0);
    rst = 1'b1;
    step();
    chk_eq("rst_mid_acc", 32'(last_acc), 32'(-1));
    rst = 1'b0;
    step();
    chk_eq("after_rst_acc", 32'(last_acc), 0);

    random_run(500);

`ifdef FIFOARB_GRANT_CNT_EN
    valid_v = '0;
    do_reset();
    for (int c = 0; c < 70000; c++) begin
      want(1);
      step();
    end
    chk_eq("cnt_sat", 32'(gcnt_b[16 +: 16]), 32'hFFFF);
    want(1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk_eq("clr_acc", 32'(last_acc), 1);
    chk_eq("cnt_clr", 32'(gcnt_b[16 +: 16]), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
